seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's common-anode seven-segment display. It owns the refresh prescaler and sequences the digit anodes and segment lines. It accepts new display words from the CPU or debug logic over a valid/ready handshake and buffers them so a word only takes effect at a frame boundary. It sits between the top-level debug/IO logic and the display pins, replacing ad-hoc refresh clocks with a single synchronous controller on clk_i.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index 0 is the rightmost entry; b and d are the lowercase glyphs.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low a..g segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with buffered word update.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
//
// state | meaning
// IDLE  | display disabled, anodes off, index and counters cleared
// SCAN  | indexed digit driven for DIV clocks
// GAP   | all anodes off for GAP_CYC clocks before the next digit
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 25_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int DIGITS  = 8,
    parameter int GAP_CYC = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int IW  = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int DW  = 4 * DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;

    logic [DW-1:0]     act_word, pend_word, act_word_nxt;
    logic [DIGITS-1:0] act_dp, pend_dp, act_dp_nxt;
    logic              pend_full;
    logic              boundary;

    logic [3:0]        nib;
    logic [6:0]        seg_dec;
    logic              blank;
    logic [DIGITS-1:0] an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    assign ready_o  = !pend_full;
    assign boundary = (state == SCAN) && (idx == '0) && (presc == '0);

    // The word swapped in at a boundary is already visible on that first digit-0 clock.
    assign act_word_nxt = (boundary && pend_full) ? pend_word : act_word;
    assign act_dp_nxt   = (boundary && pend_full) ? pend_dp   : act_dp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        presc_nxt = presc;
        gap_nxt   = gap_cnt;
        if (!en_i) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            presc_nxt = '0;
            gap_nxt   = '0;
        end else begin
            case (state)
                IDLE: state_nxt = SCAN;
                SCAN: begin
                    if (presc == PRESC_LAST) begin
                        state_nxt = GAP;
                        presc_nxt = '0;
                        gap_nxt   = '0;
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = SCAN;
                        gap_nxt   = '0;
                        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx     <= '0;
            presc   <= '0;
            gap_cnt <= '0;
        end else begin
            idx     <= idx_nxt;
            presc   <= presc_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_word  <= '0;
            act_dp    <= '0;
            pend_word <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else begin
            act_word <= act_word_nxt;
            act_dp   <= act_dp_nxt;
            if (boundary && pend_full) begin
                pend_full <= 1'b0;
            end else if (valid_i && !pend_full) begin
                pend_word <= data_i;
                pend_dp   <= dp_i;
                pend_full <= 1'b1;
            end
        end
    end

    assign nib = act_word_nxt[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nib (nib),
        .seg (seg_dec)
    );

`ifdef SEG7_LZ_BLANK_EN
    assign blank = (idx != '0) && !act_dp_nxt[idx] && ((act_word_nxt >> {idx, 2'b00}) == '0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state == SCAN && !blank) begin
            an_d[idx] = 1'b0;
            seg_d     = seg_dec;
            dp_d      = !act_dp_nxt[idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an_o    <= '1;
            seg_o   <= SEG_OFF;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            an_o    <= an_d;
            seg_o   <= seg_d;
            dp_o    <= dp_d;
            frame_o <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: positional reference model plus literal spot checks.
module tb_seg7_scan_ctrl;

    localparam int DIV   = 10;
    localparam int GAPC  = 2;
    localparam int ND    = 4;
    localparam int PER   = DIV + GAPC;
    localparam int FRAME = ND * PER;
`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i, valid_i;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic        ready_o, dp_o, frame_o;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk_i = ~clk_i;

    seg7_scan_ctrl #(.CLK_HZ(100), .SCAN_HZ(10), .DIGITS(ND), .GAP_CYC(GAPC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i), .dp_i(dp_i),
        .valid_i(valid_i), .ready_o(ready_o), .an_o(an_o), .seg_o(seg_o),
        .dp_o(dp_o), .frame_o(frame_o)
    );

    function automatic logic [6:0] hexseg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Model: m_t counts clocks since the display left IDLE; position within the frame gives digit/phase.
    logic        m_run, m_pf;
    int          m_t;
    logic [15:0] m_act, m_pend, eff_w;
    logic [3:0]  m_act_dp, m_pend_dp, eff_dp;
    logic [3:0]  e_an, x_an;
    logic [6:0]  e_seg, x_seg;
    logic        e_dp, x_dp, e_frame;
    int          pos, dig, ph;
    logic        scan, bnd, shown;

    always_comb begin
        pos    = m_t % FRAME;
        dig    = pos / PER;
        ph     = pos % PER;
        bnd    = m_run && (pos == 0);
        scan   = m_run && (ph < DIV);
        eff_w  = (bnd && m_pf) ? m_pend : m_act;
        eff_dp = (bnd && m_pf) ? m_pend_dp : m_act_dp;
        shown  = scan;
        if (LZ && dig != 0 && !eff_dp[dig] && ((eff_w >> (4 * dig)) == 16'h0)) shown = 1'b0;
        x_an  = 4'hF;
        x_seg = 7'h7F;
        x_dp  = 1'b1;
        if (shown) begin
            x_an  = ~(4'b0001 << dig);
            x_seg = hexseg(eff_w[4 * dig +: 4]);
            x_dp  = ~eff_dp[dig];
        end
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_run <= 1'b0;  m_t <= 0;  m_pf <= 1'b0;
            m_act <= '0;  m_act_dp <= '0;  m_pend <= '0;  m_pend_dp <= '0;
            e_an <= 4'hF;  e_seg <= 7'h7F;  e_dp <= 1'b1;  e_frame <= 1'b0;
        end else begin
            e_an <= x_an;  e_seg <= x_seg;  e_dp <= x_dp;  e_frame <= bnd;
            if (bnd && m_pf) begin
                m_act <= m_pend;  m_act_dp <= m_pend_dp;  m_pf <= 1'b0;
            end else if (valid_i && !m_pf) begin
                m_pend <= data_i;  m_pend_dp <= dp_i;  m_pf <= 1'b1;
            end
            if (!en_i) begin
                m_run <= 1'b0;  m_t <= 0;
            end else begin
                m_run <= 1'b1;  m_t <= m_run ? m_t + 1 : 0;
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (chk_on) begin
            n_cmp++;
            if ({an_o, seg_o, dp_o, frame_o, ready_o} !== {e_an, e_seg, e_dp, e_frame, ~m_pf}) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL model_cmp @%0t got an=%b seg=%h dp=%b fr=%b rdy=%b want an=%b seg=%h dp=%b fr=%b rdy=%b",
                             $time, an_o, seg_o, dp_o, frame_o, ready_o, e_an, e_seg, e_dp, e_frame, ~m_pf);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t got=%h want=%h", nm, $time, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!frame_o && n < 200);
        if (!frame_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout @%0t got=no_frame want=frame_within_200", $time);
        end
    endtask

    task automatic send(input logic [15:0] w, input logic [3:0] d);
        int n;
        data_i  = w;
        dp_i    = d;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout @%0t got=ready_low want=ready_high", $time);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    initial begin
        int w;
        en_i = 1'b0;  valid_i = 1'b0;  data_i = '0;  dp_i = '0;
        #2 rst_i = 1'b1;
        #1 chk("reset_out", 32'({an_o, seg_o, dp_o, frame_o, ready_o}), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}));
        chk_on = 1'b1;
        step(3);
        rst_i = 1'b0;
        step(3);
        en_i = 1'b1;

        wait_frame(w);
        chk("frame_d0_an", 32'(an_o), 32'(4'b1110));
        chk("frame_d0_seg", 32'(seg_o), 32'(7'h40));
        step(9);   chk("d0_last_an", 32'(an_o), 32'(4'b1110));
        step(1);   chk("gap_an", 32'(an_o), 32'(4'b1111));
        step(2);   chk("d1_an", 32'(an_o), 32'(4'b1101));
        step(24);  chk("d3_an", 32'(an_o), 32'(4'b0111));
        wait_frame(w);
        chk("frame_period", 32'(36 + w), 32'(48));

        step(20);
        valid_i = 1'b1;  data_i = 16'h12AB;  dp_i = 4'h0;
        @(negedge clk_i);
        chk("ready_drop", 32'(ready_o), 32'(0));
        data_i = 16'h0C0D;
        step(3);
        chk("ready_held", 32'(ready_o), 32'(0));
        wait_frame(w);
        chk("digit0_b", 32'({an_o, seg_o}), 32'({4'b1110, 7'h03}));
        @(negedge clk_i);
        chk("second_accepted", 32'(ready_o), 32'(0));
        valid_i = 1'b0;
        step(35);
        chk("digit3_1", 32'({an_o, seg_o}), 32'({4'b0111, 7'h79}));
        wait_frame(w);
        chk("digit0_d", 32'({an_o, seg_o}), 32'({4'b1110, 7'h21}));

        step(26);
        en_i = 1'b0;
        @(negedge clk_i);  chk("an_hold", 32'(an_o), 32'(4'b1011));
        @(negedge clk_i);  chk("an_off", 32'(an_o), 32'(4'b1111));
        step(3);
        en_i = 1'b1;
        step(2);
        chk("reenable_frame", 32'({frame_o, an_o}), 32'({1'b1, 4'b1110}));

        send(16'h7777, 4'h0);
        step(9);
        chk("pend_before_rst", 32'(ready_o), 32'(0));
        #3 rst_i = 1'b1;
        #1 chk("rst_async", 32'({an_o, seg_o, dp_o, frame_o, ready_o}), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}));
        step(2);
        rst_i = 1'b0;
        wait_frame(w);
        chk("rst_clears_active", 32'(seg_o), 32'(7'h40));
        wait_frame(w);
        chk("rst_drops_pending", 32'(seg_o), 32'(7'h40));

        send(16'h0005, 4'b0100);
        wait_frame(w);
        chk("lz_d0", 32'({an_o, seg_o}), 32'({4'b1110, 7'h12}));
        step(12);  chk("lz_d1", 32'(an_o), 32'(LZ ? 4'b1111 : 4'b1101));
        step(12);  chk("lz_d2", 32'({an_o, dp_o}), 32'({4'b1011, 1'b0}));
        step(12);  chk("lz_d3", 32'(an_o), 32'(LZ ? 4'b1111 : 4'b0111));

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            en_i    = ($urandom_range(0, 199) != 0);
            valid_i = ($urandom_range(0, 3) == 0);
            data_i  = $urandom_range(0, 1) ? 16'($urandom) : (16'($urandom) & 16'h00FF);
            dp_i    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        end
        @(negedge clk_i);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
